// File: rtl/fetch_stage.sv
// Instruction fetch stage: four-state FSM that requests one instruction per PC,
// holds it until decode accepts, and handles redirects including in-flight drains.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_new_pc,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_pc,
  output logic [31:0] o_instruction,
  output logic        o_instr_valid,
  input  logic        i_id_ready,
  output logic        o_align_err,
  output logic [31:0] o_instr_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_addr_q;
  logic [31:0] r_instruction;
  logic        r_instr_valid;
  logic        r_align_err;
  logic [31:0] r_instr_count;

  logic        w_accept;
  logic        w_pc_load;
  logic [31:0] w_pc_src;

  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Redirect outranks everything; a redirect racing an ack drops the data.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = i_redirect_valid ? S_IDLE : S_REQ;
      S_REQ: begin
        if (i_redirect_valid) begin
          w_next_state = i_imem_ack ? S_IDLE : S_DRAIN;
        end else begin
          w_next_state = i_imem_ack ? S_HOLD : S_REQ;
        end
      end
      S_HOLD:  w_next_state = (i_redirect_valid || i_id_ready) ? S_IDLE : S_HOLD;
      S_DRAIN: w_next_state = i_imem_ack ? S_IDLE : S_DRAIN;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    o_imem_req = 1'b0;
    case (r_state)
      S_REQ, S_DRAIN: o_imem_req = 1'b1;
      S_IDLE, S_HOLD: o_imem_req = 1'b0;
      default:        o_imem_req = 1'b0;
    endcase
  end

  always_comb begin
    w_accept  = (r_state == S_HOLD) && i_id_ready && !i_redirect_valid;
    w_pc_load = i_redirect_valid || w_accept;
    if (i_redirect_valid) begin
      w_pc_src = i_redirect_pc;
    end else begin
      w_pc_src = i_new_pc;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pc          <= RESET_PC;
      r_addr_q      <= RESET_PC;
      r_instruction <= 32'h0000_0000;
      r_instr_valid <= 1'b0;
      r_align_err   <= 1'b0;
      r_instr_count <= 32'h0000_0000;
    end else begin
      if (w_pc_load) begin
        r_pc <= align_pc(w_pc_src);
        if (is_misaligned(w_pc_src)) begin
          r_align_err <= 1'b1;
        end
      end
      if (w_accept) begin
        r_instr_count <= r_instr_count + 32'd1;
      end
      if (r_state == S_IDLE && !i_redirect_valid) begin
        r_addr_q <= r_pc;
      end
      if (r_state == S_REQ && i_imem_ack && !i_redirect_valid) begin
        r_instruction <= i_imem_rdata;
        r_instr_valid <= 1'b1;
      end else if (r_state == S_HOLD && (i_redirect_valid || i_id_ready)) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign o_imem_addr   = r_addr_q;
  assign o_pc          = r_pc;
  assign o_instruction = r_instruction;
  assign o_instr_valid = r_instr_valid;
  assign o_align_err   = r_align_err;
  assign o_instr_count = r_instr_count;

endmodule
